// File: rtl/event_stretcher.sv
// Turns each rising edge of a clean internal event into one human-visible blink:
// a fixed high time, then a guaranteed low gap; events arriving mid-blink are queued.
module event_stretcher #(
  parameter int ON_FINAL_VALUE  = 249_999,
  parameter int OFF_FINAL_VALUE = 249_999,
  parameter int PEND_WIDTH      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  event_in,
  output logic                  stretched,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending_count,
  output logic                  overflow
);

  localparam int MAX_FINAL = (ON_FINAL_VALUE > OFF_FINAL_VALUE) ? ON_FINAL_VALUE : OFF_FINAL_VALUE;
  localparam int TW        = (MAX_FINAL > 0) ? $clog2(MAX_FINAL + 1) : 1;

  localparam logic [TW-1:0]         ON_T     = TW'(ON_FINAL_VALUE);
  localparam logic [TW-1:0]         OFF_T    = TW'(OFF_FINAL_VALUE);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            event_q;
  logic            rise;
  logic            pend_full;

  assign rise      = event_in & ~event_q;
  assign pend_full = (pending_count == PEND_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      stretched     <= 1'b0;
      busy          <= 1'b0;
      pending_count <= '0;
      overflow      <= 1'b0;
      timer         <= '0;
      // Treat the input as already high so a level held through reset is not an event.
      event_q       <= 1'b1;
    end else begin
      event_q  <= event_in;
      overflow <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (rise) begin
            state     <= ON;
            stretched <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ON: begin
          if (rise) begin
            if (pend_full) overflow      <= 1'b1;
            else           pending_count <= pending_count + PEND_WIDTH'(1);
          end
          if (timer == ON_T) begin
            state     <= OFF;
            stretched <= 1'b0;
            timer     <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        OFF: begin
          if (timer == OFF_T) begin
            timer <= '0;
            // A rise on the terminal cycle starts the next blink itself; with a
            // non-empty queue it takes a slot while the oldest entry is replayed.
            if (rise || (pending_count != '0)) begin
              state     <= ON;
              stretched <= 1'b1;
              if (!rise) pending_count <= pending_count - PEND_WIDTH'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
            if (rise) begin
              if (pend_full) overflow      <= 1'b1;
              else           pending_count <= pending_count + PEND_WIDTH'(1);
            end
          end
        end

        default: begin
          state     <= IDLE;
          stretched <= 1'b0;
          busy      <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_stretcher.sv
// Bench for event_stretcher: a countdown-based blink model checked every cycle,
// directed scenarios with fixed blink/overflow counts, then randomized traffic.
module tb_event_stretcher;

  localparam int ON_F  = 3;
  localparam int OFF_F = 1;
  localparam int PW    = 2;
  localparam int PMAX  = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          event_in;
  logic          stretched;
  logic          busy;
  logic [PW-1:0] pending_count;
  logic          overflow;

  event_stretcher #(
    .ON_FINAL_VALUE (ON_F),
    .OFF_FINAL_VALUE(OFF_F),
    .PEND_WIDTH     (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .event_in     (event_in),
    .stretched    (stretched),
    .busy         (busy),
    .pending_count(pending_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: remaining high cycles, remaining low-gap cycles, queue depth.
  int m_hi = 0, m_lo = 0, m_pend = 0, m_ovf = 0, m_prev = 1;
  bit started = 0;

  task automatic m_queue();
    if (m_pend == PMAX) m_ovf = 1;
    else                m_pend++;
  endtask

  always @(posedge clk) begin
    int r;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_ovf = 0; m_prev = 1;
      started = 1;
    end else if (started) begin
      r = (event_in && !m_prev) ? 1 : 0;
      m_prev = event_in;
      m_ovf = 0;
      if (m_hi > 0) begin
        if (r) m_queue();
        m_hi--;
        if (m_hi == 0) m_lo = OFF_F + 1;
      end else if (m_lo > 0) begin
        if (m_lo == 1) begin
          m_lo = 0;
          if (r || m_pend > 0) begin
            m_hi = ON_F + 1;
            if (!r) m_pend--;
          end
        end else begin
          m_lo--;
          if (r) m_queue();
        end
      end else if (r) begin
        m_hi = ON_F + 1;
      end
    end
  end

  int blinks = 0, ovfs = 0;
  logic prev_str = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("stretched", int'(stretched), (m_hi > 0) ? 1 : 0);
      chk("busy", int'(busy), (m_hi > 0 || m_lo > 0) ? 1 : 0);
      chk("pending_count", int'(pending_count), m_pend);
      chk("overflow", int'(overflow), m_ovf);
      if (stretched && !prev_str) blinks++;
      if (overflow) ovfs++;
      prev_str = stretched;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      event_in = 1'b0;
    end
  endtask

  // Bit i of pat is the event level in the i-th driven cycle.
  task automatic run(input string tag, input logic [63:0] pat, input int len,
                     input int exp_blinks, input int exp_ovf);
    int b0, o0;
    @(negedge clk);
    b0 = blinks; o0 = ovfs;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      event_in = pat[i];
    end
    idle(45);
    chk({tag, "_blinks"}, blinks - b0, exp_blinks);
    chk({tag, "_ovf"}, ovfs - o0, exp_ovf);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int b0;
    reset = 1'b1;
    event_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stretched", int'(stretched), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending_count), 0);
    reset = 1'b0;
    idle(3);

    run("single",    64'h1,     1,  1, 0);
    run("held",      64'hFFFFF, 20, 1, 0);
    run("three",     64'h15,    5,  3, 0);
    run("overflow",  64'h555,   11, 5, 1);
    run("term_p0",   64'h41,    7,  2, 0);
    run("term_p1",   64'h45,    7,  3, 0);

    // Reset mid-blink with queued events and the input held high across release.
    @(negedge clk); event_in = 1'b1;
    @(negedge clk); event_in = 1'b0;
    @(negedge clk); event_in = 1'b1;
    @(negedge clk); event_in = 1'b0;
    @(negedge clk); event_in = 1'b1;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst6_stretched", int'(stretched), 0);
    chk("rst6_busy", int'(busy), 0);
    chk("rst6_pending", int'(pending_count), 0);
    chk("rst6_overflow", int'(overflow), 0);
    b0 = blinks;
    repeat (10) @(negedge clk);
    chk("rst6_noblink", blinks - b0, 0);
    event_in = 1'b0;
    @(negedge clk); event_in = 1'b1;
    @(negedge clk); event_in = 1'b0;
    idle(10);
    chk("rst6_reblink", blinks - b0, 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      event_in = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
